axil_wb_bridge: RTL and testbench

AXIL_WB_BRIDGE -- requirements
Module: axil_wb_bridge
Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 18, meaning AXI and WB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data width; byte lanes = DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning max WB cycles awaited before abort (1..65535).
REQ-004 SHALL have port wb_clk_i  in  1  sole clock; everything below is synchronous to it.
REQ-005 SHALL have port wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port s_axi_awaddr  in  ADDR_WIDTH  write address.
REQ-007 SHALL have port s_axi_awvalid  in  1  write address valid.
REQ-008 SHALL have port s_axi_awready  out  1  write address ready.
REQ-009 SHALL have port s_axi_wdata  in  DATA_WIDTH  write data.
REQ-010 SHALL have port s_axi_wstrb  in  DATA_WIDTH/8  write byte strobes.
REQ-011 SHALL have port s_axi_wvalid  in  1  write data valid.
REQ-012 SHALL have port s_axi_wready  out  1  write data ready.
REQ-013 SHALL have port s_axi_bresp  out  2  write response.
REQ-014 SHALL have port s_axi_bvalid  out  1  write response valid.
REQ-015 SHALL have port s_axi_bready  in  1  write response ready.
REQ-016 SHALL have port s_axi_araddr  in  ADDR_WIDTH  read address.
REQ-017 SHALL have port s_axi_arvalid  in  1  read address valid.
REQ-018 SHALL have port s_axi_arready  out  1  read address ready.
REQ-019 SHALL have port s_axi_rdata  out  DATA_WIDTH  read data.
REQ-020 SHALL have port s_axi_rresp  out  2  read response.
REQ-021 SHALL have port s_axi_rvalid  out  1  read data valid.
REQ-022 SHALL have port s_axi_rready  in  1  read data ready.
REQ-023 SHALL have port wb_cyc_o  out  1  WB cycle.
REQ-024 SHALL have port wb_stb_o  out  1  WB strobe, always equal to wb_cyc_o.
REQ-025 SHALL have port wb_we_o  out  1  WB write enable.
REQ-026 SHALL have port wb_adr_o  out  ADDR_WIDTH  WB address.
REQ-027 SHALL have port wb_dat_o  out  DATA_WIDTH  WB write data.
REQ-028 SHALL have port wb_sel_o  out  DATA_WIDTH/8  WB byte selects.
REQ-029 SHALL have port wb_dat_i  in  DATA_WIDTH  WB read data.
REQ-030 SHALL have port wb_ack_i  in  1  WB acknowledge.
REQ-031 SHALL have port wb_err_i  in  1  WB error.
REQ-032 SHALL have port timeout_o  out  1  one-cycle pulse on WB timeout abort.
Function
REQ-033 SHALL hold AW, W, AR each in a one-entry register; awready=!aw_full, wready=!w_full, arready=!ar_full; entry fills on valid&&ready, AW and W independent, any order.
REQ-034 SHALL run FSM IDLE->WB_WR|WB_RD->B_RESP|R_RESP->IDLE; one WB transaction outstanding, classic single cycles only.
REQ-035 IDLE: write eligible when aw_full&&w_full, read when ar_full; both eligible -> grant opposite of last granted type (round-robin, reset value: last=read, so write wins first).
REQ-036 Grant at edge N SHALL drive cyc/stb=1 from N+1 with adr/dat/sel/we from the held entries, stable until termination.
REQ-037 WB_WR/WB_RD SHALL terminate on ack_i or err_i sampled with cyc=1 (ack wins if both); cyc/stb drop the next cycle, same edge that sets bvalid/rvalid.
REQ-038 Response codes: ack->OKAY 2'b00; err->SLVERR 2'b10; timeout->DECERR 2'b11.
REQ-039 rdata SHALL capture wb_dat_i on ack, 0 on err/timeout; rdata/rresp/bresp stable while valid.
REQ-040 Timeout counter SHALL clear at grant, count cycles with cyc=1; reaching TIMEOUT without termination -> abort, cyc drop, timeout_o=1 one cycle, DECERR response.
REQ-041 B_RESP/R_RESP: bvalid/rvalid held until bready/rready; at handshake edge clear consumed entries (aw+w or ar) and return to IDLE; next grant no earlier than following cycle.
REQ-042 New AW/W/AR SHALL be acceptable during any state while the corresponding entry is empty.
Reset
REQ-043 wb_rst_i=1 SHALL asynchronously force IDLE, all entries empty, counter 0, last=read, and every output 0 (readies rise first clock after release); mid-transaction reset drops cyc immediately, transaction discarded.
Verification
REQ-044 Write 0x1234 addr 0x00040 wstrb 0xF, ack after 3 cycles -> WB we=1 sel=0xF dat=0x00001234, bresp=00 once.
REQ-045 Read addr 0x00100, wb_dat_i=0xDEADBEEF with ack -> rdata=0xDEADBEEF, rresp=00; W before AW by 5 cycles -> single write issued only after AW.
REQ-046 Simultaneous write and read after reset -> write WB cycle first, then read; two more pairs alternate strictly.
REQ-047 No ack, TIMEOUT=16 -> cyc high exactly 16 cycles, timeout_o pulse, rresp=11, rdata=0; err_i on write -> bresp=10.
REQ-048 bready held low 10 cycles -> bvalid/bresp stable, no new WB cycle; reset asserted during WB_RD -> cyc=0 same cycle, no rvalid after release.

---
 rtl/axil_wb_bridge.sv | 126 ++++++++++++
 tb/tb_axil_wb_bridge.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_wb_bridge.sv
// axil_wb_bridge: AXI4-Lite slave to Wishbone classic master, one WB transaction in flight with timeout abort
module axil_wb_bridge #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  output logic                    timeout_o
);
  localparam int SW = DATA_WIDTH / 8;
  typedef enum logic [2:0] {IDLE, WB_WR, WB_RD, B_RESP, R_RESP} state_t;
  state_t state, state_nxt;
  logic rdy_en, aw_full, w_full, ar_full, last_rd;
  logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [SW-1:0] w_strb;
  logic [15:0] cnt;
  logic on_wr, on_rd, cyc, done, tmo, grant_wr, grant_rd, b_hs, r_hs;
  logic [1:0] resp;
  assign on_wr = state == WB_WR;
  assign on_rd = state == WB_RD;
  assign cyc = on_wr || on_rd;
  // ack/err on the last allowed cycle still beats the timeout
  assign done = cyc && (wb_ack_i || wb_err_i || cnt == 16'(TIMEOUT - 1));
  assign tmo = done && !wb_ack_i && !wb_err_i;
  assign resp = wb_ack_i ? 2'b00 : wb_err_i ? 2'b10 : 2'b11;
  assign grant_wr = state == IDLE && aw_full && w_full && (!ar_full || last_rd);
  assign grant_rd = state == IDLE && ar_full && !grant_wr;
  assign b_hs = state == B_RESP && s_axi_bready;
  assign r_hs = state == R_RESP && s_axi_rready;
  assign s_axi_awready = rdy_en && !aw_full;
  assign s_axi_wready = rdy_en && !w_full;
  assign s_axi_arready = rdy_en && !ar_full;
  assign s_axi_bvalid = state == B_RESP;
  assign s_axi_rvalid = state == R_RESP;
  assign wb_cyc_o = cyc;
  assign wb_stb_o = cyc;
  assign wb_we_o = on_wr;
  assign wb_adr_o = on_wr ? aw_addr : on_rd ? ar_addr : '0;
  assign wb_dat_o = on_wr ? w_data : '0;
  assign wb_sel_o = on_wr ? w_strb : on_rd ? '1 : '0;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = grant_wr ? WB_WR : grant_rd ? WB_RD : IDLE;
      WB_WR:   state_nxt = done ? B_RESP : WB_WR;
      WB_RD:   state_nxt = done ? R_RESP : WB_RD;
      B_RESP:  state_nxt = s_axi_bready ? IDLE : B_RESP;
      R_RESP:  state_nxt = s_axi_rready ? IDLE : R_RESP;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rdy_en <= 1'b0;
      aw_full <= 1'b0;
      w_full <= 1'b0;
      ar_full <= 1'b0;
      aw_addr <= '0;
      ar_addr <= '0;
      w_data <= '0;
      w_strb <= '0;
      last_rd <= 1'b1;
      cnt <= '0;
      timeout_o <= 1'b0;
      s_axi_bresp <= 2'b00;
      s_axi_rresp <= 2'b00;
      s_axi_rdata <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (s_axi_awvalid && s_axi_awready) begin
        aw_full <= 1'b1;
        aw_addr <= s_axi_awaddr;
      end else if (b_hs) aw_full <= 1'b0;
      if (s_axi_wvalid && s_axi_wready) begin
        w_full <= 1'b1;
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end else if (b_hs) w_full <= 1'b0;
      if (s_axi_arvalid && s_axi_arready) begin
        ar_full <= 1'b1;
        ar_addr <= s_axi_araddr;
      end else if (r_hs) ar_full <= 1'b0;
      if (grant_wr || grant_rd) begin
        cnt <= '0;
        last_rd <= grant_rd;
      end else if (cyc) cnt <= cnt + 16'd1;
      timeout_o <= tmo;
      if (on_wr && done) s_axi_bresp <= resp;
      if (on_rd && done) begin
        s_axi_rresp <= resp;
        s_axi_rdata <= wb_ack_i ? wb_dat_i : '0;
      end
    end
  end
endmodule

// File: tb/tb_axil_wb_bridge.sv
// tb_axil_wb_bridge: directed and randomized checks of axil_wb_bridge against a transaction-level model
module tb_axil_wb_bridge;
  localparam int AW = 18, DW = 32, SW = 4, TO = 16;
  logic clk = 0, rst = 1;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
  logic [DW-1:0] wdata = '0, wb_dat_i = '0;
  logic [SW-1:0] wstrb = '0;
  logic wb_ack_i = 0, wb_err_i = 0;
  logic awready, wready, bvalid, arready, rvalid, cyc, stb, we, tmo;
  logic [1:0] bresp, rresp;
  logic [DW-1:0] rdata, dat_o;
  logic [AW-1:0] adr;
  logic [SW-1:0] sel;

  axil_wb_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr), .wb_dat_o(dat_o),
    .wb_sel_o(sel), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Wishbone slave: mode 0 ack, 1 err, 2 silent, 3 ack+err together
  int s_mode = 0, s_lat = 0, s_cnt = 0, cur_mode = 0, cur_lat = 0, r = 0;
  bit s_rand = 0, s_dat_fix = 0;
  logic [DW-1:0] s_dat = '0;
  always begin
    @(posedge clk);
    #1;
    wb_ack_i = 0;
    wb_err_i = 0;
    wb_dat_i = s_dat_fix ? s_dat : $urandom;
    if (cyc) begin
      if (s_cnt == 0) begin
        if (s_rand) begin
          r = $urandom % 20;
          cur_mode = r < 12 ? 0 : r < 15 ? 1 : r < 17 ? 3 : 2;
          cur_lat = $urandom % 6;
        end else begin
          cur_mode = s_mode;
          cur_lat = s_lat;
        end
      end
      if (cur_mode != 2 && s_cnt == cur_lat) begin
        wb_ack_i = cur_mode == 0 || cur_mode == 3;
        wb_err_i = cur_mode == 1 || cur_mode == 3;
      end
      s_cnt++;
    end else s_cnt = 0;
  end

  // Reference model: held requests, current transaction and pending response
  bit m_rdy, m_awf, m_wf, m_arf, m_last_rd, m_onbus, m_bv, m_rv, m_tmo;
  logic [AW-1:0] m_awa, m_ara;
  logic [DW-1:0] m_wd, m_rdata;
  logic [SW-1:0] m_ws;
  logic [1:0] m_bresp, m_rresp;
  int m_cur, m_cyc;

  task automatic m_reset();
    m_rdy = 0; m_awf = 0; m_wf = 0; m_arf = 0; m_last_rd = 1; m_onbus = 0;
    m_bv = 0; m_rv = 0; m_tmo = 0; m_cur = 0; m_cyc = 0;
  endtask

  task automatic m_step();
    bit aw_take, w_take, ar_take, tmo_n;
    aw_take = awvalid && m_rdy && !m_awf;
    w_take = wvalid && m_rdy && !m_wf;
    ar_take = arvalid && m_rdy && !m_arf;
    tmo_n = 0;
    if (m_onbus) begin
      m_cyc++;
      if (wb_ack_i || wb_err_i || m_cyc == TO) begin
        tmo_n = !wb_ack_i && !wb_err_i;
        m_onbus = 0;
        if (m_cur == 1) begin
          m_bv = 1;
          m_bresp = wb_ack_i ? 2'b00 : wb_err_i ? 2'b10 : 2'b11;
        end else begin
          m_rv = 1;
          m_rresp = wb_ack_i ? 2'b00 : wb_err_i ? 2'b10 : 2'b11;
          m_rdata = wb_ack_i ? wb_dat_i : '0;
        end
      end
    end else if (m_bv) begin
      if (bready) begin m_bv = 0; m_awf = 0; m_wf = 0; m_cur = 0; end
    end else if (m_rv) begin
      if (rready) begin m_rv = 0; m_arf = 0; m_cur = 0; end
    end else if (m_awf && m_wf && (!m_arf || m_last_rd)) begin
      m_cur = 1; m_onbus = 1; m_cyc = 0; m_last_rd = 0;
    end else if (m_arf) begin
      m_cur = 2; m_onbus = 1; m_cyc = 0; m_last_rd = 1;
    end
    if (aw_take) begin m_awf = 1; m_awa = awaddr; end
    if (w_take) begin m_wf = 1; m_wd = wdata; m_ws = wstrb; end
    if (ar_take) begin m_arf = 1; m_ara = araddr; end
    m_rdy = 1;
    m_tmo = tmo_n;
  endtask

  // Observation log for the directed expectations
  int n_b = 0, n_r = 0, n_wb = 0, n_tmo = 0, n_rv_seen = 0, cyc_len = 0;
  bit prev_cyc = 0, lw_we = 0;
  logic [AW-1:0] lw_adr = '0;
  logic [DW-1:0] lw_dat = '0, last_rdata = '0;
  logic [SW-1:0] lw_sel = '0;
  logic [1:0] last_bresp = '0, last_rresp = '0;
  bit we_log[$];

  always @(negedge clk) begin
    if (rst) begin
      m_reset();
      chk("rst_bresp", bresp, 0);
      chk("rst_rresp", rresp, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_adr", adr, 0);
      chk("rst_wdat", dat_o, 0);
      chk("rst_sel", sel, 0);
    end
    chk("awready", awready, m_rdy && !m_awf);
    chk("wready", wready, m_rdy && !m_wf);
    chk("arready", arready, m_rdy && !m_arf);
    chk("cyc", cyc, m_onbus);
    chk("stb", stb, m_onbus);
    chk("we", we, m_onbus && m_cur == 1);
    chk("bvalid", bvalid, m_bv);
    chk("rvalid", rvalid, m_rv);
    chk("timeout_o", tmo, m_tmo);
    if (m_onbus) chk("adr", adr, m_cur == 1 ? m_awa : m_ara);
    if (m_onbus && m_cur == 1) begin
      chk("wdat", dat_o, m_wd);
      chk("sel", sel, m_ws);
    end
    if (m_bv) chk("bresp", bresp, m_bresp);
    if (m_rv) begin
      chk("rresp", rresp, m_rresp);
      chk("rdata", rdata, m_rdata);
    end
    if (!rst) begin
      if (cyc) begin
        if (!prev_cyc) begin
          n_wb++; we_log.push_back(we);
          lw_we = we; lw_adr = adr; lw_dat = dat_o; lw_sel = sel; cyc_len = 0;
        end
        cyc_len++;
      end
      if (bvalid && bready) begin n_b++; last_bresp = bresp; end
      if (rvalid && rready) begin n_r++; last_rresp = rresp; last_rdata = rdata; end
      if (rvalid) n_rv_seen++;
      if (tmo) n_tmo++;
      m_step();
    end
    prev_cyc = cyc;
  end

  task automatic do_aw(input logic [AW-1:0] a);
    bit ok = 0;
    @(posedge clk); #1;
    awaddr = a; awvalid = 1;
    repeat (200) begin @(negedge clk); if (awready) begin ok = 1; break; end end
    chk("aw_handshake", ok, 1);
    @(posedge clk); #1 awvalid = 0;
  endtask

  task automatic do_w(input logic [DW-1:0] d, input logic [SW-1:0] s);
    bit ok = 0;
    @(posedge clk); #1;
    wdata = d; wstrb = s; wvalid = 1;
    repeat (200) begin @(negedge clk); if (wready) begin ok = 1; break; end end
    chk("w_handshake", ok, 1);
    @(posedge clk); #1 wvalid = 0;
  endtask

  task automatic do_ar(input logic [AW-1:0] a);
    bit ok = 0;
    @(posedge clk); #1;
    araddr = a; arvalid = 1;
    repeat (200) begin @(negedge clk); if (arready) begin ok = 1; break; end end
    chk("ar_handshake", ok, 1);
    @(posedge clk); #1 arvalid = 0;
  endtask

  task automatic wait_b(input int n0);
    bit ok = 0;
    repeat (300) begin @(negedge clk); #1; if (n_b > n0) begin ok = 1; break; end end
    chk("wait_b", ok, 1);
  endtask

  task automatic wait_r(input int n0);
    bit ok = 0;
    repeat (300) begin @(negedge clk); #1; if (n_r > n0) begin ok = 1; break; end end
    chk("wait_r", ok, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  int nb, nr, nw, nt, nrv;
  bit ok;
  bit aw_hs, w_hs, ar_hs;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk); chk("rdy_before_first_edge", awready, 0);
    @(negedge clk); chk("rdy_after_first_edge", awready, 1);

    s_mode = 0; s_lat = 3; nb = n_b; nw = n_wb;
    fork do_aw(18'h00040); do_w(32'h0000_1234, 4'hF); join
    wait_b(nb);
    chk("wr_we", lw_we, 1);
    chk("wr_sel", lw_sel, 4'hF);
    chk("wr_dat", lw_dat, 32'h0000_1234);
    chk("wr_adr", lw_adr, 18'h00040);
    chk("wr_cyc_len", cyc_len, 4);
    chk("wr_bresp", last_bresp, 2'b00);
    repeat (5) @(negedge clk);
    chk("wr_bresp_once", n_b - nb, 1);
    chk("wr_one_wb", n_wb - nw, 1);

    s_dat_fix = 1; s_dat = 32'hDEAD_BEEF; s_lat = 1; nr = n_r;
    do_ar(18'h00100);
    wait_r(nr);
    chk("rd_we", lw_we, 0);
    chk("rd_adr", lw_adr, 18'h00100);
    chk("rd_rdata", last_rdata, 32'hDEAD_BEEF);
    chk("rd_rresp", last_rresp, 2'b00);

    nw = n_wb; nb = n_b;
    do_w(32'hA5A5_0001, 4'h3);
    repeat (5) @(posedge clk);
    chk("w_first_no_wb", n_wb - nw, 0);
    do_aw(18'h00200);
    wait_b(nb);
    chk("w_first_one_wb", n_wb - nw, 1);
    chk("w_first_adr", lw_adr, 18'h00200);
    chk("w_first_sel", lw_sel, 4'h3);

    do_reset();
    we_log.delete();
    s_dat_fix = 0; s_lat = 0;
    for (int p = 0; p < 3; p++) begin
      nb = n_b; nr = n_r;
      fork
        do_aw(AW'(18'h01000 + p * 4));
        do_w(DW'(32'h100 + p), 4'hF);
        do_ar(AW'(18'h02000 + p * 4));
      join
      wait_b(nb);
      wait_r(nr);
    end
    chk("rr_count", we_log.size(), 6);
    for (int i = 0; i < 6 && i < we_log.size(); i++) chk("rr_order", we_log[i], i % 2 == 0);

    s_mode = 2; nr = n_r; nt = n_tmo;
    do_ar(18'h30000);
    wait_r(nr);
    chk("to_cyc_len", cyc_len, TO);
    chk("to_pulse", n_tmo - nt, 1);
    chk("to_rresp", last_rresp, 2'b11);
    chk("to_rdata", last_rdata, 0);

    s_mode = 1; s_lat = 2; nb = n_b;
    fork do_aw(18'h00044); do_w(32'h5555_AAAA, 4'hC); join
    wait_b(nb);
    chk("err_bresp", last_bresp, 2'b10);

    s_mode = 0; s_lat = 0;
    @(posedge clk); #1 bready = 0;
    fork do_aw(18'h00048); do_w(32'h0BAD_F00D, 4'h1); join
    ok = 0;
    repeat (50) begin @(negedge clk); if (bvalid) begin ok = 1; break; end end
    chk("bhold_seen", ok, 1);
    nw = n_wb; nr = n_r;
    do_ar(18'h00055);
    repeat (10) begin
      @(negedge clk);
      chk("bhold_bvalid", bvalid, 1);
      chk("bhold_bresp", bresp, 2'b00);
    end
    chk("bhold_no_wb", n_wb - nw, 0);
    @(posedge clk); #1 bready = 1;
    wait_r(nr);
    chk("bhold_then_read", n_wb - nw, 1);

    s_mode = 2;
    do_ar(18'h00077);
    ok = 0;
    repeat (20) begin @(negedge clk); if (cyc) begin ok = 1; break; end end
    chk("rst_mid_cyc_seen", ok, 1);
    @(posedge clk); #3 rst = 1;
    #1 chk("rst_mid_cyc_drop", cyc, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    nrv = n_rv_seen;
    repeat (30) @(negedge clk);
    chk("rst_mid_no_rvalid", n_rv_seen - nrv, 0);

    s_rand = 1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs = wvalid && wready;
      ar_hs = arvalid && arready;
      @(posedge clk); #1;
      if (aw_hs) awvalid = 0;
      if (w_hs) wvalid = 0;
      if (ar_hs) arvalid = 0;
      if (!awvalid && $urandom % 4 == 0) begin awvalid = 1; awaddr = AW'($urandom); end
      if (!wvalid && $urandom % 4 == 0) begin wvalid = 1; wdata = $urandom; wstrb = SW'($urandom); end
      if (!arvalid && $urandom % 4 == 0) begin arvalid = 1; araddr = AW'($urandom); end
      bready = $urandom % 3 != 0;
      rready = $urandom % 3 != 0;
    end
    @(negedge clk);
    aw_hs = awvalid && awready;
    w_hs = wvalid && wready;
    ar_hs = arvalid && arready;
    @(posedge clk); #1;
    if (aw_hs) awvalid = 0;
    if (w_hs) wvalid = 0;
    if (ar_hs) arvalid = 0;
    bready = 1; rready = 1;
    repeat (100) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
